up_bram_banked: RTL
===================

Name: up_bram_banked

Overview:
- Parametrised successor to the single-bank up_ipif BRAM slave.
- Exposes C_NUM_BANKS block-RAM banks behind one UP_WR/UP_RD register interface:
  - byte-enabled writes;
  - pipelined reads with configurable latency;
  - out-of-range detection with a saturating error counter.
- A second, user-side port B gives fabric logic concurrent access to the same banks, e.g. for coefficient tables or capture buffers.

Parameters:
- C_ADDR_WIDTH, 14: up_ipif word-address width.
- C_DATA_WIDTH, 32: data width, multiple of 8.
- C_NUM_BANKS, 4: number of banks, 1..8, need not be a power of two.
- C_BANK_AW, 10: log2 words per bank.
- C_RD_LATENCY, 2: read latency in clk cycles, legal range 1..4.
- C_OOR_DATA, 32'hDEAD_BEEF: read data returned for out-of-range reads. Truncated or zero-extended to C_DATA_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- up_wr_addr  in  C_ADDR_WIDTH  UP_WR word address.
- up_wr_be  in  C_DATA_WIDTH/8  UP_WR byte enables.
- up_wr_req  in  1  UP_WR request pulse.
- up_wr_din  in  C_DATA_WIDTH  UP_WR write data.
- up_wr_ack  out  1  UP_WR acknowledge.
- up_rd_addr  in  C_ADDR_WIDTH  UP_RD word address.
- up_rd_req  in  1  UP_RD request pulse.
- up_rd_dout  out  C_DATA_WIDTH  UP_RD read data.
- up_rd_ack  out  1  UP_RD acknowledge.
- b_en  in  1  port B access enable.
- b_we  in  C_DATA_WIDTH/8  port B byte write enables.
- b_addr  in  C_ADDR_WIDTH  port B word address.
- b_din  in  C_DATA_WIDTH  port B write data.
- b_dout  out  C_DATA_WIDTH  port B read data.
- b_valid  out  1  port B read-data valid.
- oor_count  out  16  saturating count of out-of-range accesses from UP_WR, UP_RD and port B.

Behaviour:
- Address decode:
  - bank = addr[C_BANK_AW +: clog2(C_NUM_BANKS)]; offset = addr[C_BANK_AW-1:0].
  - Out-of-range (OOR): bank >= C_NUM_BANKS, or any address bit above the bank field is nonzero.
  - C_NUM_BANKS = 1 uses a zero-width bank field; every address bit above C_BANK_AW must then be 0.
- Reset:
  - up_wr_ack, up_rd_ack and b_valid = 0; up_rd_dout and b_dout = 0; oor_count = 0.
  - Read pipelines are flushed; memory contents are not reset.
  - Reset asserted mid-read drops all pending acks. No ack appears after reset deasserts for requests issued before it.
- UP_WR:
  - Each up_wr_req cycle writes, in the same edge, the bytes with be=1 to the addressed bank.
  - up_wr_ack is a 1-cycle pulse exactly 1 cycle after req.
  - be = 0 still acks.
  - An OOR write acks, modifies no memory and increments oor_count.
- UP_RD:
  - Fully pipelined; a req is accepted every cycle.
  - up_rd_ack pulses exactly C_RD_LATENCY cycles after req; acks come in request order.
  - up_rd_dout is valid with the ack and holds its value until the next ack.
  - An OOR read acks at the same latency with dout = C_OOR_DATA and increments oor_count.
- Port B:
  - b_en with b_we = 0 is a read: b_valid pulses C_RD_LATENCY cycles later with b_dout, which holds until the next b_valid.
  - b_en with b_we != 0 is a byte write: no b_valid.
  - An OOR port B access is ignored; b_valid is still generated for an OOR read, with C_OOR_DATA; oor_count increments.
- Collisions (same bank and offset, same cycle):
  - A read concurrent with a write from the other port, or from the UP_WR side, returns old data (read-first).
  - UP_WR and port B writing the same word: UP_WR bytes win for overlapping byte lanes; non-overlapping lanes from both are written.
- oor_count:
  - Increments by the number of OOR events in the cycle (0..3) and saturates at 16'hFFFF.
  - It is not cleared except by rst.
- Bank read mux: output is selected by the bank index delayed through the read pipeline, so mixed-bank back-to-back reads return correct data.

Test Plan:
- Reset then idle (defaults: C_NUM_BANKS=4, C_BANK_AW=10, C_RD_LATENCY=2) -> all outputs 0. Write addr 0x0005, be=4'hF, din 0x11223344 -> up_wr_ack at cycle +1. Read 0x0005 -> ack at +2, dout 0x11223344.
- Byte enables: write 0xFFFFFFFF, then write be=4'b0101 din 0x00AA00BB to 0x0405 (bank 1) -> read returns 0xFFAAFFBB; bank 0 addr 0x0005 unchanged.
- Pipelined reads: reqs on 4 consecutive cycles to banks 0, 1, 2, 3 at offset 7 (preloaded 0xA0..0xA3) -> 4 consecutive acks, dout 0xA0, 0xA1, 0xA2, 0xA3 in order.
- OOR: C_NUM_BANKS=3, read 0x0C00 -> ack at +2, dout 0xDEADBEEF, oor_count=1. Write 0x0C00 -> ack, no memory change, oor_count=2. Force count to 0xFFFF -> stays at 0xFFFF.
- Collision: same cycle, UP_WR 0x0010 be=4'hF din 0x1, port B write 0x0010 we=4'hF din 0x2, port B read of 0x0010 on the next cycle -> read returns 0x1. A port B read concurrent with the write returns old data.
- Reset mid-read: up_rd_req, rst asserted 1 cycle later for 2 cycles -> no up_rd_ack ever; dout = 0; the next read behaves normally.

Source files
------------

// File: rtl/up_bram_banked_if.sv
// rtl/up_bram_banked_if.sv - UP_WR/UP_RD and port B bus bundle for up_bram_banked
`timescale 1ns/1ps
interface up_bram_banked_if #(
  parameter int C_ADDR_WIDTH = 14,
  parameter int C_DATA_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0]   up_wr_addr;
  logic [C_DATA_WIDTH/8-1:0] up_wr_be;
  logic                      up_wr_req;
  logic [C_DATA_WIDTH-1:0]   up_wr_din;
  logic                      up_wr_ack;
  logic [C_ADDR_WIDTH-1:0]   up_rd_addr;
  logic                      up_rd_req;
  logic [C_DATA_WIDTH-1:0]   up_rd_dout;
  logic                      up_rd_ack;
  logic                      b_en;
  logic [C_DATA_WIDTH/8-1:0] b_we;
  logic [C_ADDR_WIDTH-1:0]   b_addr;
  logic [C_DATA_WIDTH-1:0]   b_din;
  logic [C_DATA_WIDTH-1:0]   b_dout;
  logic                      b_valid;
  logic [15:0]               oor_count;

  modport master (
    output up_wr_addr, up_wr_be, up_wr_req, up_wr_din,
    input  up_wr_ack,
    output up_rd_addr, up_rd_req,
    input  up_rd_dout, up_rd_ack,
    output b_en, b_we, b_addr, b_din,
    input  b_dout, b_valid, oor_count
  );

  modport slave (
    input  up_wr_addr, up_wr_be, up_wr_req, up_wr_din,
    output up_wr_ack,
    input  up_rd_addr, up_rd_req,
    output up_rd_dout, up_rd_ack,
    input  b_en, b_we, b_addr, b_din,
    output b_dout, b_valid, oor_count
  );
endinterface

// File: rtl/up_bram_banked.sv
// rtl/up_bram_banked.sv - multi-bank BRAM behind UP_WR/UP_RD with a second fabric port B
`timescale 1ns/1ps
module up_bram_banked #(
  parameter int          C_ADDR_WIDTH = 14,
  parameter int          C_DATA_WIDTH = 32,
  parameter int          C_NUM_BANKS  = 4,
  parameter int          C_BANK_AW    = 10,
  parameter int          C_RD_LATENCY = 2,
  parameter logic [31:0] C_OOR_DATA   = 32'hDEAD_BEEF
) (
  input logic             clk,
  input logic             rst,
  up_bram_banked_if.slave bus
);
  localparam int NBE = C_DATA_WIDTH / 8;
  localparam int BW  = (C_NUM_BANKS > 1) ? $clog2(C_NUM_BANKS) : 0;
  localparam int BI  = (BW > 0) ? BW : 1;
  localparam int BIP = BI + 1;
  localparam int L   = C_RD_LATENCY;
  localparam int PD  = (L > 1) ? L - 1 : 1;
  localparam logic [C_DATA_WIDTH-1:0] OOR_DATA = C_DATA_WIDTH'(C_OOR_DATA);
  localparam logic [BI:0]             NB_L     = BIP'(C_NUM_BANKS);

  typedef struct packed {
    logic                 oor;
    logic [BI-1:0]        bank;
    logic [C_BANK_AW-1:0] off;
  } dec_t;

  // With one bank the bank field is empty, so every bit above the offset must be zero.
  function automatic dec_t decode(input logic [C_ADDR_WIDTH-1:0] a);
    logic [C_ADDR_WIDTH-1:0] hi;
    dec_t d;
    hi     = a >> C_BANK_AW;
    d.off  = a[C_BANK_AW-1:0];
    d.bank = hi[BI-1:0];
    d.oor  = (hi >> BW) != '0;
    if (C_NUM_BANKS > 1 && {1'b0, d.bank} >= NB_L) d.oor = 1'b1;
    return d;
  endfunction

  dec_t wr_d, rd_d, b_d;
  logic wr_hit, rd_hit, b_rd, b_rd_hit, b_wr_hit;

  assign wr_d     = decode(bus.up_wr_addr);
  assign rd_d     = decode(bus.up_rd_addr);
  assign b_d      = decode(bus.b_addr);
  assign wr_hit   = bus.up_wr_req & ~wr_d.oor;
  assign rd_hit   = bus.up_rd_req & ~rd_d.oor;
  assign b_rd     = bus.b_en & (bus.b_we == '0);
  assign b_rd_hit = b_rd & ~b_d.oor;
  assign b_wr_hit = bus.b_en & (|bus.b_we) & ~b_d.oor;

  logic [C_DATA_WIDTH-1:0] mem    [C_NUM_BANKS][2**C_BANK_AW];
  logic [C_DATA_WIDTH-1:0] bank_q [2][C_NUM_BANKS];

  // Reads sample before this edge's writes land (read-first); UP_WR lanes are
  // assigned after port B so they win on overlapping bytes.
  always_ff @(posedge clk) begin
    if (rd_hit)   bank_q[0][rd_d.bank] <= mem[rd_d.bank][rd_d.off];
    if (b_rd_hit) bank_q[1][b_d.bank]  <= mem[b_d.bank][b_d.off];
    for (int i = 0; i < NBE; i++) begin
      if (b_wr_hit && bus.b_we[i])
        mem[b_d.bank][b_d.off][i*8 +: 8] <= bus.b_din[i*8 +: 8];
      if (wr_hit && bus.up_wr_be[i])
        mem[wr_d.bank][wr_d.off][i*8 +: 8] <= bus.up_wr_din[i*8 +: 8];
    end
  end

  logic                    req_in  [2];
  logic                    oor_in  [2];
  logic [BI-1:0]           bank_in [2];
  logic [L-1:0]            vld     [2];
  logic                    oor_s1  [2];
  logic [BI-1:0]           bank_s1 [2];
  logic [C_DATA_WIDTH-1:0] pipe    [2][PD];
  logic [C_DATA_WIDTH-1:0] hold    [2];
  logic [C_DATA_WIDTH-1:0] mux_s1  [2];
  logic [C_DATA_WIDTH-1:0] out_s   [2];
  logic                    wr_ack;
  logic [15:0]             oor_cnt;
  logic [1:0]              oor_inc;
  logic [16:0]             oor_sum;

  assign req_in[0]  = bus.up_rd_req;
  assign req_in[1]  = b_rd;
  assign oor_in[0]  = rd_d.oor;
  assign oor_in[1]  = b_d.oor;
  assign bank_in[0] = rd_d.bank;
  assign bank_in[1] = b_d.bank;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      mux_s1[c] = oor_s1[c] ? OOR_DATA : bank_q[c][bank_s1[c]];
      out_s[c]  = (L == 1) ? mux_s1[c] : pipe[c][PD-1];
    end
    oor_inc = 2'(bus.up_wr_req & wr_d.oor) + 2'(bus.up_rd_req & rd_d.oor)
            + 2'(bus.b_en & b_d.oor);
    oor_sum = {1'b0, oor_cnt} + 17'(oor_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        vld[c]     <= '0;
        oor_s1[c]  <= 1'b0;
        bank_s1[c] <= '0;
        hold[c]    <= '0;
        for (int j = 0; j < PD; j++) pipe[c][j] <= '0;
      end
      wr_ack  <= 1'b0;
      oor_cnt <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        vld[c] <= (vld[c] << 1) | L'(req_in[c]);
        if (req_in[c]) begin
          oor_s1[c]  <= oor_in[c];
          bank_s1[c] <= bank_in[c];
        end
        pipe[c][0] <= mux_s1[c];
        for (int j = 1; j < PD; j++) pipe[c][j] <= pipe[c][j-1];
        if (vld[c][L-1]) hold[c] <= out_s[c];
      end
      wr_ack  <= bus.up_wr_req;
      oor_cnt <= oor_sum[16] ? 16'hFFFF : oor_sum[15:0];
    end
  end

  assign bus.up_wr_ack  = wr_ack;
  assign bus.up_rd_ack  = vld[0][L-1];
  assign bus.up_rd_dout = vld[0][L-1] ? out_s[0] : hold[0];
  assign bus.b_valid    = vld[1][L-1];
  assign bus.b_dout     = vld[1][L-1] ? out_s[1] : hold[1];
  assign bus.oor_count  = oor_cnt;
endmodule
